// File: rtl/mem_req_unit_if.sv
// Request/response bus between the MEM-stage initiator and the memory access controller.
// The initiator drives rw/addr/wdata/bits; the controller answers with a done pulse and rdata.
interface mem_req_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [1:0]        rw;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [4:0]        bits;
  logic              done;
  logic [31:0]       rdata;

  modport master (
    output rw,
    output addr,
    output wdata,
    output bits,
    input  done,
    input  rdata
  );

  modport slave (
    input  rw,
    input  addr,
    input  wdata,
    input  bits,
    output done,
    output rdata
  );
endinterface

// File: rtl/mem_req_unit.sv
// MEM-stage load/store initiator: issues one controller request per memory uop, stalls upstream
// until done, extends load data and forwards non-memory results to writeback.
module mem_req_unit #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [1:0]        ex_mem_op_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [31:0]       ex_wdata_i,
  input  logic [31:0]       ex_alu_result_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              ex_wb_en_i,
  mem_req_unit_if.master    ctrl,
  output logic              stall_req_o,
  output logic              wb_valid_o,
  output logic              wb_en_o,
  output logic [4:0]        wb_rd_o,
  output logic [31:0]       wb_data_o,
  output logic              mem_err_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  localparam logic [1:0] OpNone  = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;

  logic [0:0]        state_q, state_d;
  logic [1:0]        rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [4:0]        bits_q, bits_d;
  logic [4:0]        rd_q, rd_d;
  logic              rd_wen_q, rd_wen_d;
  logic [2:0]        funct3_q, funct3_d;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic              mem_err_q, mem_err_d;

  logic              is_mem;
  logic              legal;
  logic              accept;
  logic [4:0]        size_bits;
  logic [31:0]       size_wdata;
  logic [31:0]       load_ext;

  // Decode of the incoming uop; only meaningful in IDLE.
  always_comb begin
    is_mem = (ex_mem_op_i == OpLoad) || (ex_mem_op_i == OpStore);
    legal  = 1'b0;
    case (ex_funct3_i)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = (ex_mem_op_i == OpLoad);
      default:                legal = 1'b0;
    endcase
    accept = (state_q == StIdle) && ex_valid_i && is_mem && legal;
  end

  always_comb begin
    size_bits  = 5'd31;
    size_wdata = ex_wdata_i;
    case (ex_funct3_i[1:0])
      2'b00: begin
        size_bits  = 5'd7;
        size_wdata = {24'b0, ex_wdata_i[7:0]};
      end
      2'b01: begin
        size_bits  = 5'd15;
        size_wdata = {16'b0, ex_wdata_i[15:0]};
      end
      default: begin
        size_bits  = 5'd31;
        size_wdata = ex_wdata_i;
      end
    endcase
  end

  // Extension uses the funct3 latched at accept, since ex_* is don't-care while BUSY.
  always_comb begin
    load_ext = ctrl.rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{ctrl.rdata[7]}}, ctrl.rdata[7:0]};
      3'b001:  load_ext = {{16{ctrl.rdata[15]}}, ctrl.rdata[15:0]};
      3'b100:  load_ext = {24'b0, ctrl.rdata[7:0]};
      3'b101:  load_ext = {16'b0, ctrl.rdata[15:0]};
      default: load_ext = ctrl.rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bits_d     = bits_q;
    rd_d       = rd_q;
    rd_wen_d   = rd_wen_q;
    funct3_d   = funct3_q;
    wb_valid_d = 1'b0;
    wb_en_d    = wb_en_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mem_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // ctrl.done is deliberately not looked at here.
        if (accept) begin
          state_d  = StBusy;
          rw_d     = ex_mem_op_i;
          addr_d   = ex_addr_i;
          bits_d   = size_bits;
          wdata_d  = (ex_mem_op_i == OpStore) ? size_wdata : 32'b0;
          rd_d     = ex_rd_i;
          rd_wen_d = ex_wb_en_i;
          funct3_d = ex_funct3_i;
        end else if (ex_valid_i && !is_mem) begin
          wb_valid_d = 1'b1;
          wb_en_d    = ex_wb_en_i;
          wb_rd_d    = ex_rd_i;
          wb_data_d  = ex_alu_result_i;
        end else if (ex_valid_i) begin
          mem_err_d = 1'b1;
        end
      end
      StBusy: begin
        if (ctrl.done) begin
          state_d    = StIdle;
          rw_d       = OpNone;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (rw_q == OpLoad) begin
            wb_en_d   = rd_wen_q;
            wb_data_d = load_ext;
          end else begin
            wb_en_d   = 1'b0;
            wb_data_d = 32'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rw_q       <= OpNone;
      addr_q     <= '0;
      wdata_q    <= 32'b0;
      bits_q     <= 5'b0;
      rd_q       <= 5'b0;
      rd_wen_q   <= 1'b0;
      funct3_q   <= 3'b0;
      wb_valid_q <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_rd_q    <= 5'b0;
      wb_data_q  <= 32'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bits_q     <= bits_d;
      rd_q       <= rd_d;
      rd_wen_q   <= rd_wen_d;
      funct3_q   <= funct3_d;
      wb_valid_q <= wb_valid_d;
      wb_en_q    <= wb_en_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign ctrl.rw    = rw_q;
  assign ctrl.addr  = addr_q;
  assign ctrl.wdata = wdata_q;
  assign ctrl.bits  = bits_q;

  // Gated by rst so upstream is released immediately when reset asserts.
  assign stall_req_o = rst & (accept | (state_q == StBusy));

  assign wb_valid_o = wb_valid_q;
  assign wb_en_o    = wb_en_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_data_o  = wb_data_q;
  assign mem_err_o  = mem_err_q;

endmodule

// File: doc/mem_req_unit.md
Name: mem_req_unit

Overview:
- MEM-stage initiator for the memory access controller. It accepts load/store µops from EX/MEM and drives the controller's request interface (rw/addr/data/bits), holding each request until the controller signals done.
- Sign- or zero-extends load data and returns results to writeback.
- Passes non-memory results straight through.
- Asserts stall to the upstream pipeline while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, address width of ex_addr and ctrl_addr.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX/MEM slot holds an instruction
- ex_mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none
- ex_funct3  in  3  RV32I load/store funct3
- ex_addr  in  ADDR_W  effective byte address
- ex_wdata  in  32  store data (rs2)
- ex_alu_result  in  32  result of a non-memory instruction
- ex_rd  in  5  destination register
- ex_wb_en  in  1  instruction writes rd
- ctrl_rw  out  2  00 idle, 01 load, 10 store
- ctrl_addr  out  ADDR_W  request start byte address
- ctrl_wdata  out  32  store data, size-masked
- ctrl_bits  out  5  MSB index of the access: 7 byte, 15 half, 31 word
- ctrl_done  in  1  one-cycle pulse: transaction complete
- ctrl_rdata  in  32  load data, little-endian, byte at ctrl_addr in [7:0], valid with ctrl_done
- stall_req  out  1  hold EX/MEM and earlier stages
- wb_valid  out  1  one-cycle pulse: wb_* fields valid
- wb_en  out  1  write wb_data to wb_rd
- wb_rd  out  5  destination register
- wb_data  out  32  result
- mem_err  out  1  one-cycle pulse: illegal funct3 for a load/store

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - ctrl_rw=00, ctrl_addr=0, ctrl_wdata=0, ctrl_bits=0.
  - wb_valid=0, wb_en=0, wb_rd=0, wb_data=0, mem_err=0.
  - stall_req=0 while rst=0.
  - Reset mid-transaction abandons the request; the controller shares this reset.
- States: IDLE, BUSY.
- Legal funct3:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
- accept = IDLE & ex_valid & ex_mem_op∈{01,10} & funct3 legal.
- IDLE, on clock edge:
  - accept: go to BUSY. Register ctrl_rw=ex_mem_op, ctrl_addr=ex_addr, ctrl_bits from size.
    - ctrl_wdata = ex_wdata masked to size, upper bits 0; 0 for loads.
    - Latch ex_rd, ex_wb_en, funct3.
  - ex_valid & op∈{00,11}: wb_valid=1, wb_en=ex_wb_en, wb_rd=ex_rd, wb_data=ex_alu_result. Latency 1.
  - ex_valid & op∈{01,10} & illegal funct3: mem_err=1, wb_valid=0, no request issued.
  - Otherwise: wb_valid=0, mem_err=0.
- BUSY:
  - ctrl_* outputs held stable every cycle.
  - When ctrl_done=1: on that edge ctrl_rw→00, state→IDLE, wb_valid=1, wb_rd=latched rd.
    - Load: wb_en=latched wb_en, wb_data=extended ctrl_rdata.
    - Store: wb_en=0, wb_data=0.
- Extension of load data:
  - LB: {24{rdata[7]},rdata[7:0]}
  - LH: {16{rdata[15]},rdata[15:0]}
  - LW: rdata
  - LBU: zero-extended [7:0]
  - LHU: zero-extended [15:0]
- stall_req = accept | (state==BUSY), combinational.
  - Falls in the cycle after the ctrl_done edge; upstream advances then.
- Back-to-back requests: a new request may be accepted in the first IDLE cycle after completion. Minimum ctrl_rw=00 gap is 1 cycle.
- ctrl_done is ignored in IDLE, including the accept cycle; only BUSY-state done counts.
- ctrl_done arriving on the first BUSY cycle (zero-wait controller) is legal. Total latency is 2 edges from accept to wb_valid.
- ex_* inputs are ignored while BUSY; upstream holds them under stall.
- No address alignment check. Byte-serial access makes any address legal, and ctrl_addr + 3 wraps modulo 2^ADDR_W.

Test Plan:
- Reset mid-BUSY: assert rst=0 while ctrl_rw=01 -> ctrl_rw=00, stall_req=0, wb_valid=0 immediately, with no clock. After release, state is IDLE.
- LB from 0x100, ctrl_rdata=0x000000F3, done 4 cycles after request:
  - stall_req high from the accept cycle until the done edge.
  - wb_valid one cycle, wb_data=0xFFFFFFF3.
  - ctrl_rw=01 and ctrl_bits=7 throughout BUSY.
- LHU/LH/LW with ctrl_rdata=0x8001ABCD -> 0x0000ABCD / 0xFFFFABCD / 0x8001ABCD.
- SH to 0x204 with ex_wdata=0x12345678 -> ctrl_rw=10, ctrl_wdata=0x00005678, ctrl_bits=15. On done: wb_valid=1, wb_en=0.
- Zero-wait: ctrl_done on the first BUSY cycle -> wb_valid 2 edges after accept. An immediate following ALU op (ex_alu_result=0x55) -> wb_data=0x55 one edge later.
- Illegal load funct3=011 -> mem_err pulse, ctrl_rw stays 00, stall_req=0.
- Spurious ctrl_done in IDLE -> wb_valid stays 0.
